// File: rtl/servo_pwm_driver_if.sv
// Command/status bundle between the tracking FSM (master) and one servo driver (slave).
interface servo_pwm_driver_if;
   logic        move_cw;
   logic        move_ccw;
   logic        load;
   logic [31:0] load_value;
   logic        servo;
   logic [31:0] servo_position;
   logic        pwm_limit_cw;
   logic        pwm_limit_ccw;
   logic        period_start;

   modport master (
      output move_cw, move_ccw, load, load_value,
      input  servo, servo_position, pwm_limit_cw, pwm_limit_ccw, period_start
   );

   modport slave (
      input  move_cw, move_ccw, load, load_value,
      output servo, servo_position, pwm_limit_cw, pwm_limit_ccw, period_start
   );
endinterface

// File: rtl/servo_pwm_driver.sv
// Single-axis servo driver: saturating pulse-width position register stepped or loaded by
// the tracking FSM, and a 50 Hz PWM whose duty is latched only at period boundaries.
module servo_pwm_driver #(
   parameter int unsigned PERIOD    = 2000000,
   parameter int unsigned MIN_PW    = 100000,
   parameter int unsigned MAX_PW    = 200000,
   parameter int unsigned CENTER_PW = 150000,
   parameter int unsigned STEP      = 100,
   parameter int unsigned STEP_DIV  = 10000
) (
   input logic                clk_i,
   input logic                rst_i,
   servo_pwm_driver_if.slave  bus_io
);

   localparam logic [31:0] PeriodLast  = 32'(PERIOD - 1);
   localparam logic [31:0] MinPw       = 32'(MIN_PW);
   localparam logic [31:0] MaxPw       = 32'(MAX_PW);
   localparam logic [31:0] CenterPw    = 32'(CENTER_PW);
   localparam logic [32:0] Step33      = 33'(STEP);
   localparam logic [31:0] StepDivLast = 32'(STEP_DIV - 1);

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] active_pw_q, active_pw_d;
   logic [31:0] pos_q, pos_d;
   logic [31:0] presc_q, presc_d;
   logic        servo_q, servo_d;
   logic        ps_q, ps_d;
   logic        lim_cw_q, lim_cw_d;
   logic        lim_ccw_q, lim_ccw_d;

   logic [32:0] sum_up, diff_dn;
   logic [31:0] up_pos, dn_pos, load_pos;
   logic        single_move;

   // Next-state: period counter, PWM compare, position stepping/loading with saturation.
   always_comb begin
      cnt_d       = (cnt_q == PeriodLast) ? '0 : cnt_q + 32'd1;
      servo_d     = (cnt_q < active_pw_q);
      ps_d        = (cnt_q == '0);
      // Duty only changes at the period boundary so no runt pulse is ever emitted.
      active_pw_d = (cnt_q == PeriodLast) ? pos_q : active_pw_q;

      // 33-bit arithmetic so overflow/underflow is visible before clamping.
      sum_up  = {1'b0, pos_q} + Step33;
      diff_dn = {1'b0, pos_q} - Step33;
      up_pos  = (sum_up > {1'b0, MaxPw}) ? MaxPw : sum_up[31:0];
      dn_pos  = (diff_dn[32] || (diff_dn[31:0] < MinPw)) ? MinPw : diff_dn[31:0];

      if (bus_io.load_value < MinPw) begin
         load_pos = MinPw;
      end else if (bus_io.load_value > MaxPw) begin
         load_pos = MaxPw;
      end else begin
         load_pos = bus_io.load_value;
      end

      single_move = bus_io.move_cw ^ bus_io.move_ccw;
      pos_d       = pos_q;
      presc_d     = presc_q;

      if (bus_io.load) begin
         pos_d   = load_pos;
         presc_d = '0;
      end else if (single_move) begin
         if (presc_q == StepDivLast) begin
            presc_d = '0;
            pos_d   = bus_io.move_cw ? up_pos : dn_pos;
         end else begin
            presc_d = presc_q + 32'd1;
         end
      end else begin
         presc_d = '0;
      end

      // Flags follow the new position on the same edge that updates it.
      lim_cw_d  = (pos_d == MaxPw);
      lim_ccw_d = (pos_d == MinPw);
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         active_pw_q <= CenterPw;
         pos_q       <= CenterPw;
         presc_q     <= '0;
         servo_q     <= 1'b0;
         ps_q        <= 1'b0;
         lim_cw_q    <= 1'b0;
         lim_ccw_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         active_pw_q <= active_pw_d;
         pos_q       <= pos_d;
         presc_q     <= presc_d;
         servo_q     <= servo_d;
         ps_q        <= ps_d;
         lim_cw_q    <= lim_cw_d;
         lim_ccw_q   <= lim_ccw_d;
      end
   end

   assign bus_io.servo          = servo_q;
   assign bus_io.servo_position = pos_q;
   assign bus_io.pwm_limit_cw   = lim_cw_q;
   assign bus_io.pwm_limit_ccw  = lim_ccw_q;
   assign bus_io.period_start   = ps_q;

endmodule
